// File: rtl/regfile_frame_stack.sv
// regfile_frame_stack: dual-read/dual-write register file with a hardware call-frame stack
module regfile_frame_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int SAVE_BASE = 16,
    parameter int SAVE_REGS = 16,
    parameter int FRAMES = 4,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int DW = $clog2(FRAMES + 1),
    localparam int FW = FRAMES > 1 ? $clog2(FRAMES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              a1,
    input  logic [AW-1:0]              a2,
    input  logic                       r1_en,
    input  logic                       r2_en,
    input  logic [AW-1:0]              wa1,
    input  logic [AW-1:0]              wa2,
    input  logic [WIDTH-1:0]           w1,
    input  logic [WIDTH-1:0]           w2,
    input  logic                       w1_en,
    input  logic                       w2_en,
    input  logic                       save,
    input  logic                       restore,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           r1,
    output logic [WIDTH-1:0]           r2,
    output logic [WIDTH*SAVE_REGS-1:0] frame_out,
    output logic [DW-1:0]              depth,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);
    logic [WIDTH-1:0] rf [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic [WIDTH*SAVE_REGS-1:0] slot [FRAMES];
    logic [WIDTH*SAVE_REGS-1:0] win;
    logic [FW-1:0] top;
    logic do_save, do_restore, err_set;

    assign full = depth == DW'(FRAMES);
    assign empty = depth == '0;
    assign top = FW'(depth - DW'(1));
    assign frame_out = empty ? '0 : slot[top];
    assign do_save = save && !restore && !full;
    assign do_restore = restore && !save && !empty;
    assign err_set = (save && restore) || (save && full) || (restore && empty);

    always_comb begin
        nxt = rf;
        win = '0;
        for (int i = 0; i < SAVE_REGS; i++) win[i*WIDTH +: WIDTH] = rf[SAVE_BASE+i];
        if (w1_en) nxt[wa1] = w1;
        if (w2_en) nxt[wa2] = w2;
        if (do_restore)
            for (int i = 0; i < SAVE_REGS; i++) nxt[SAVE_BASE+i] = slot[top][i*WIDTH +: WIDTH];
        if (ZERO_REG != 0) nxt[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf <= '{default: '0};
            slot <= '{default: '0};
            r1 <= '0;
            r2 <= '0;
            depth <= '0;
            err <= 1'b0;
        end else begin
            rf <= nxt;
            if (r1_en) r1 <= nxt[a1];
            if (r2_en) r2 <= nxt[a2];
            if (do_save) begin
                slot[FW'(depth)] <= win;
                depth <= depth + DW'(1);
            end
            if (do_restore) depth <= depth - DW'(1);
            err <= err_set || (err && !err_clr);
        end
    end
endmodule
